rib_rr_arbiter: RTL and testbench

//  Registered grant arbiter for the shared RIB master port. Serialises NUM_M bus masters (core ex, core pc

---
 rtl/rib_rr_arbiter.sv | 140 ++++++++++++++
 tb/tb_rib_rr_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/rib_rr_arbiter.sv
// rib_rr_arbiter
// Registered grant arbiter for the shared RIB master port. Serialises NUM_M
// bus masters onto the single slave-side path. Priority-class masters (debug)
// win and preempt. All other masters share round-robin with a bounded tenure.
// Drives the core pipeline hold flag.
//
// Ports
//   clk          clock
//   rst          synchronous reset, active-high
//   req_i        per-master request (level, held until done)
//   lock_i       per-master lock; the owner keeps the grant while set
//   grant_o      one-hot registered grant, all-zero when idle
//   grant_idx_o  index of the owner, 0 when idle
//   grant_vld_o  |grant_o
//   hold_flag_o  a non-core master owns the bus, or a core master waits
//
// state | meaning
// IDLE  | no owner, grant_o == 0
// GRANT | grant_idx_o owns the bus, hold_cnt counts its tenure
module rib_rr_arbiter #(
  parameter int               NUM_M     = 4,
  parameter int               MAX_HOLD  = 8,
  parameter logic [NUM_M-1:0] PRIO_MASK = 4'b1100,
  parameter logic [NUM_M-1:0] CORE_MASK = 4'b0011
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_M-1:0]         req_i,
  input  logic [NUM_M-1:0]         lock_i,
  output logic [NUM_M-1:0]         grant_o,
  output logic [$clog2(NUM_M)-1:0] grant_idx_o,
  output logic                     grant_vld_o,
  output logic                     hold_flag_o
);

  localparam int IW = $clog2(NUM_M);
  localparam int HW = $clog2(MAX_HOLD + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state, state_nxt;
  logic [HW-1:0]    hold_cnt, hold_nxt, hold_inc;
  logic [IW-1:0]    rr_ptr, idx_nxt;
  logic             new_grant;
  logic [NUM_M-1:0] others;

  // Priority class: fixed lowest-index-first. Otherwise scan round-robin
  // starting just after the last non-priority winner.
  function automatic logic [IW-1:0] pick(input logic [NUM_M-1:0] c,
                                         input logic [IW-1:0]    ptr);
    logic [NUM_M-1:0] pc;
    logic [IW-1:0]    idx;
    logic             found;
    pick  = '0;
    found = 1'b0;
    pc    = c & PRIO_MASK;
    if (|pc) begin
      for (int i = NUM_M - 1; i >= 0; i--) begin
        if (pc[IW'(i)]) pick = IW'(i);
      end
    end else begin
      for (int k = 1; k <= NUM_M; k++) begin
        idx = IW'((int'(ptr) + k) % NUM_M);
        if (!found && c[idx]) begin
          pick  = idx;
          found = 1'b1;
        end
      end
    end
  endfunction

  // grant_o is the owner one-hot, so this masks the owner out of req_i.
  assign others   = req_i & ~grant_o;
  assign hold_inc = (hold_cnt == HW'(MAX_HOLD)) ? hold_cnt : hold_cnt + HW'(1);

  always_comb begin
    state_nxt = state;
    idx_nxt   = grant_idx_o;
    hold_nxt  = hold_cnt;
    new_grant = 1'b0;
    case (state)
      IDLE: begin
        if (|req_i) begin
          state_nxt = GRANT;
          idx_nxt   = pick(req_i, rr_ptr);
          hold_nxt  = '0;
          new_grant = 1'b1;
        end
      end
      GRANT: begin
        if (!req_i[grant_idx_o]) begin
          // Hand straight over on release so there is no idle bubble.
          if (|others) begin
            idx_nxt   = pick(others, rr_ptr);
            new_grant = 1'b1;
          end else begin
            state_nxt = IDLE;
            idx_nxt   = '0;
          end
          hold_nxt = '0;
        end else if (lock_i[grant_idx_o]) begin
          hold_nxt = hold_inc;
        end else if (!PRIO_MASK[grant_idx_o] && |(req_i & PRIO_MASK)) begin
          idx_nxt   = pick(others, rr_ptr);
          hold_nxt  = '0;
          new_grant = 1'b1;
        end else if (hold_cnt >= HW'(MAX_HOLD - 1) && |others) begin
          idx_nxt   = pick(others, rr_ptr);
          hold_nxt  = '0;
          new_grant = 1'b1;
        end else begin
          hold_nxt = hold_inc;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grant_o     <= '0;
      grant_idx_o <= '0;
      grant_vld_o <= 1'b0;
      hold_cnt    <= '0;
      rr_ptr      <= IW'(NUM_M - 1);
    end else begin
      state       <= state_nxt;
      hold_cnt    <= hold_nxt;
      grant_idx_o <= idx_nxt;
      grant_vld_o <= (state_nxt == GRANT);
      grant_o     <= (state_nxt == GRANT) ? (NUM_M'(1) << idx_nxt) : '0;
      // Priority grants do not disturb the round-robin order.
      if (new_grant && !PRIO_MASK[idx_nxt]) rr_ptr <= idx_nxt;
    end
  end

  assign hold_flag_o = (|(grant_o & ~CORE_MASK)) | (|(req_i & CORE_MASK & ~grant_o));

endmodule

// File: tb/tb_rib_rr_arbiter.sv
module tb_rib_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] lock;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       grant_vld;
  logic       hold_flag;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: owner (-1 = idle), cycles owned so far, last RR winner.
  int m_owner = -1;
  int m_ten   = 0;
  int m_rr    = 3;
  logic [3:0] prio_m;
  logic [3:0] core_m;

  rib_rr_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req),
    .lock_i      (lock),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .grant_vld_o (grant_vld),
    .hold_flag_o (hold_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int pick_m(input logic [3:0] c);
    for (int i = 0; i < 4; i++) if (c[i] && prio_m[i]) return i;
    for (int k = 1; k <= 4; k++) begin
      int j;
      j = (m_rr + k) % 4;
      if (c[j]) return j;
    end
    return -1;
  endfunction

  task automatic give(input int x);
    m_owner = x;
    m_ten   = 1;
    if (!prio_m[x]) m_rr = x;
  endtask

  task automatic model_step(input logic [3:0] r, input logic [3:0] l, input logic rs);
    logic [3:0] oth;
    if (rs) begin
      m_owner = -1; m_ten = 0; m_rr = 3;
    end else if (m_owner < 0) begin
      if (r != 0) give(pick_m(r));
    end else begin
      oth = r;
      oth[m_owner] = 1'b0;
      if (!r[m_owner]) begin
        if (oth != 0) give(pick_m(oth));
        else m_owner = -1;
      end else if (l[m_owner]) begin
        m_ten++;
      end else if (!prio_m[m_owner] && (r & prio_m) != 0) begin
        give(pick_m(oth));
      end else if (m_ten >= 8 && oth != 0) begin
        give(pick_m(oth));
      end else begin
        m_ten++;
      end
    end
  endtask

  // Drive inputs, clock once, advance the model, compare everything.
  task automatic step(input logic [3:0] r, input logic [3:0] l, input logic rs);
    logic [3:0] eg;
    logic       ef;
    req = r; lock = l; rst = rs;
    @(posedge clk);
    model_step(r, l, rs);
    #1;
    eg = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    ef = 1'b0;
    if (m_owner >= 0 && !core_m[m_owner]) ef = 1'b1;
    for (int i = 0; i < 4; i++) if (r[i] && core_m[i] && i != m_owner) ef = 1'b1;
    check("grant", 32'(grant), 32'(eg));
    check("grant_idx", 32'(grant_idx), (m_owner < 0) ? 32'd0 : 32'(m_owner));
    check("grant_vld", 32'(grant_vld), 32'(m_owner >= 0));
    check("hold_flag", 32'(hold_flag), 32'(ef));
  endtask

  initial begin
    logic [3:0] r, l;
    prio_m = 4'b1100;
    core_m = 4'b0011;
    req = '0; lock = '0; rst = 1'b1;

    // 1: reset with everything requesting, then debug m2 wins.
    step(4'hF, 4'h0, 1'b1);
    step(4'hF, 4'h0, 1'b1);
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_hold_flag", 32'(hold_flag), 32'h1);
    step(4'hF, 4'h0, 1'b0);
    check("post_rst_grant", 32'(grant), 32'b0100);

    // 2: round-robin between the two cores, 8-cycle tenure.
    step(4'h0, 4'h0, 1'b1);
    for (int c = 1; c <= 24; c++) begin
      step(4'b0011, 4'h0, 1'b0);
      check("rr_grant", 32'(grant), (((c - 1) / 8) % 2 == 0) ? 32'b0001 : 32'b0010);
      check("rr_hold_flag", 32'(hold_flag), 32'h1);
    end

    // 3: debug preempts m0, then hands to waiting m1 with no bubble.
    step(4'h0, 4'h0, 1'b1);
    for (int c = 0; c < 3; c++) step(4'b0011, 4'h0, 1'b0);
    check("pre_owner", 32'(grant), 32'b0001);
    step(4'b0111, 4'h0, 1'b0);
    check("preempt_grant", 32'(grant), 32'b0100);
    check("preempt_hold_flag", 32'(hold_flag), 32'h1);
    step(4'b0011, 4'h0, 1'b0);
    check("after_preempt", 32'(grant), 32'b0010);

    // 4: lock keeps m0 past the tenure limit; release hands to m1.
    step(4'h0, 4'h0, 1'b1);
    step(4'b0001, 4'b0001, 1'b0);
    for (int c = 0; c < 20; c++) begin
      step(4'b0011, 4'b0001, 1'b0);
      check("lock_keep", 32'(grant), 32'b0001);
    end
    step(4'b0011, 4'h0, 1'b0);
    check("unlock_rotate", 32'(grant), 32'b0010);

    // 5: debug tie, fixed priority inside the class, then idle.
    step(4'h0, 4'h0, 1'b1);
    step(4'b1100, 4'h0, 1'b0);
    check("tie_first", 32'(grant), 32'b0100);
    step(4'b1000, 4'h0, 1'b0);
    check("tie_second", 32'(grant), 32'b1000);
    step(4'b0000, 4'h0, 1'b0);
    check("tie_idle", 32'(grant), 32'h0);
    check("tie_idle_vld", 32'(grant_vld), 32'h0);

    // 6: lone master keeps the bus, counter saturates, then rotates at once.
    step(4'h0, 4'h0, 1'b1);
    for (int c = 0; c < 50; c++) begin
      step(4'b0001, 4'h0, 1'b0);
      check("single_grant", 32'(grant), 32'b0001);
      check("single_hold_flag", 32'(hold_flag), 32'h0);
    end
    check("single_hold_cnt", 32'(dut.hold_cnt), 32'd8);
    step(4'b0011, 4'h0, 1'b0);
    check("single_then_rotate", 32'(grant), 32'b0010);

    // Reset mid-grant clears the grant even while locked.
    step(4'b0011, 4'b0011, 1'b1);
    check("rst_locked", 32'(grant), 32'h0);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      r = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) r[3:2] = 2'b00;
      l = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      step(r, l, ($urandom_range(0, 299) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
